// File: rtl/rgb_gray_pkg.sv
// Shared constants for the RGB-to-gray luma stage: fixed-point weights and
// the channel layout of the packed 3*WIDTH pixel word.
package rgb_gray_pkg;
    localparam int COEF_R = 77;
    localparam int COEF_G = 150;
    localparam int COEF_B = 29;
    localparam int ROUND  = 128;
    localparam int SHIFT  = 8;

    // Channel index within data_in, in units of WIDTH bits
    localparam int R_CH = 2;
    localparam int G_CH = 1;
    localparam int B_CH = 0;
endpackage

// File: rtl/rgb_to_gray_stream_if.sv
// Pixel stream bundle between an RGB source and the gray converter.
// The slave side is the converter; the master side feeds it and observes results.
interface rgb_to_gray_stream_if #(
    parameter int WIDTH     = 8,
    parameter int LINE_BITS = 10
);
    logic [3*WIDTH-1:0]   data_in;
    logic                 data_in_done;
    logic [WIDTH-1:0]     data_out;
    logic                 data_out_done;
    logic [LINE_BITS-1:0] col_out;
    logic [LINE_BITS-1:0] row_out;
    logic                 frame_done;

    modport master (
        output data_in, data_in_done,
        input  data_out, data_out_done, col_out, row_out, frame_done
    );

    modport slave (
        input  data_in, data_in_done,
        output data_out, data_out_done, col_out, row_out, frame_done
    );
endinterface

// File: rtl/raster_position_counter.sv
// Column/row raster counter over a ROWS x COLS frame; advances once per pulse
// and wraps to 0/0 after the last pixel with no dead cycle.
module raster_position_counter #(
    parameter int LINE_BITS = 10,
    parameter int ROWS      = 5,
    parameter int COLS      = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 advance,
    output logic [LINE_BITS-1:0] col,
    output logic [LINE_BITS-1:0] row,
    output logic                 last
);
    localparam logic [LINE_BITS-1:0] COL_LAST = LINE_BITS'(COLS - 1);
    localparam logic [LINE_BITS-1:0] ROW_LAST = LINE_BITS'(ROWS - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (col == COL_LAST) && (row == ROW_LAST);
endmodule

// File: rtl/rgb_to_gray_stream.sv
// Three-stage non-stalling RGB -> gray luma pipeline with raster position
// tracking on the output side for the downstream line buffer.
module rgb_to_gray_stream #(
    parameter int WIDTH     = 8,
    parameter int LINE_BITS = 10,
    parameter int ROWS      = 5,
    parameter int COLS      = 6
) (
    input logic                  clk,
    input logic                  reset,
    rgb_to_gray_stream_if.slave  bus
);
    import rgb_gray_pkg::*;

    localparam int STAGES = 3;
    localparam int PW     = 2 * WIDTH;
    localparam int SW     = 2 * WIDTH + 2;
    localparam logic [SW-1:0] GRAY_MAX = SW'((1 << WIDTH) - 1);

    logic [STAGES:1]      vld_pipe;
    logic [WIDTH-1:0]     r, g, b;
    logic [PW-1:0]        prod_r, prod_g, prod_b;
    logic [SW-1:0]        sum;
    logic [SW-1:0]        shifted;
    logic [WIDTH-1:0]     gray_sat;
    logic [LINE_BITS-1:0] col, row;
    logic                 last;

    assign r = bus.data_in[R_CH*WIDTH +: WIDTH];
    assign g = bus.data_in[G_CH*WIDTH +: WIDTH];
    assign b = bus.data_in[B_CH*WIDTH +: WIDTH];

    // Valid bits shift unconditionally: the pipe never stalls, so input gaps reappear verbatim
    always_ff @(posedge clk) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:1], bus.data_in_done};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_r <= '0;
            prod_g <= '0;
            prod_b <= '0;
            sum    <= '0;
        end else begin
            prod_r <= PW'(r) * PW'(COEF_R);
            prod_g <= PW'(g) * PW'(COEF_G);
            prod_b <= PW'(b) * PW'(COEF_B);
            sum    <= SW'(prod_r) + SW'(prod_g) + SW'(prod_b) + SW'(ROUND);
        end
    end

    // Saturation is dead logic at WIDTH=8 but keeps wider channels safe
    assign shifted  = sum >> SHIFT;
    assign gray_sat = (shifted > GRAY_MAX) ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];

    // Counter holds the position of the next output; it is latched alongside data_out
    raster_position_counter #(
        .LINE_BITS (LINE_BITS),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .advance (vld_pipe[STAGES-1]),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_out      <= '0;
            bus.data_out_done <= 1'b0;
            bus.col_out       <= '0;
            bus.row_out       <= '0;
            bus.frame_done    <= 1'b0;
        end else begin
            bus.data_out_done <= vld_pipe[STAGES-1];
            bus.frame_done    <= vld_pipe[STAGES-1] && last;
            if (vld_pipe[STAGES-1]) begin
                bus.data_out <= gray_sat;
                bus.col_out  <= col;
                bus.row_out  <= row;
            end
        end
    end
endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Directed + randomized bench for rgb_to_gray_stream against a luma/raster model.
module tb_rgb_to_gray_stream;
    localparam int W    = 8;
    localparam int LB   = 10;
    localparam int ROWS = 5;
    localparam int COLS = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rgb_to_gray_stream_if #(.WIDTH(W), .LINE_BITS(LB)) bus ();

    rgb_to_gray_stream #(
        .WIDTH(W), .LINE_BITS(LB), .ROWS(ROWS), .COLS(COLS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int due;
        int gray;
    } exp_t;

    exp_t q[$];
    int edge_n    = 0;
    int out_idx   = 0;
    int n_chk     = 0;
    int n_fail    = 0;
    int held_gray = 0;
    int held_col  = 0;
    int held_row  = 0;

    function automatic int luma(int r, int g, int b);
        int y;
        y = (77 * r + 150 * g + 29 * b + 128) / 256;
        return (y > 255) ? 255 : y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, got, want, edge_n);
        end
    endtask

    // One clock: drive inputs, update the model, advance, then check outputs.
    // want < 0 means use the luma model; otherwise it is a hand-computed value.
    task automatic step(input bit rst, input bit v, input int r, input int g, input int b,
                        input int want);
        exp_t e;
        int   col, row;
        reset            = rst;
        bus.data_in_done = v;
        bus.data_in      = {8'(r), 8'(g), 8'(b)};
        if (rst) begin
            q.delete();
            out_idx   = 0;
            held_gray = 0;
            held_col  = 0;
            held_row  = 0;
        end else if (v) begin
            e.due  = edge_n + 3;
            e.gray = (want < 0) ? luma(r, g, b) : want;
            q.push_back(e);
        end
        @(posedge clk);
        edge_n++;
        #1;
        if (q.size() > 0 && q[0].due == edge_n) begin
            e   = q.pop_front();
            col = out_idx % COLS;
            row = (out_idx / COLS) % ROWS;
            out_idx++;
            chk("out_done", 32'(bus.data_out_done), 1);
            chk("out_data", 32'(bus.data_out), e.gray);
            chk("out_col", 32'(bus.col_out), col);
            chk("out_row", 32'(bus.row_out), row);
            chk("out_frame", 32'(bus.frame_done), (col == COLS - 1 && row == ROWS - 1) ? 1 : 0);
            held_gray = e.gray;
            held_col  = col;
            held_row  = row;
        end else begin
            chk("idle_done", 32'(bus.data_out_done), 0);
            chk("hold_data", 32'(bus.data_out), held_gray);
            chk("hold_col", 32'(bus.col_out), held_col);
            chk("hold_row", 32'(bus.row_out), held_row);
            chk("idle_frame", 32'(bus.frame_done), 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, -1);
    endtask

    task automatic rand_pix(input bit v);
        step(1'b0, v, int'($urandom_range(255)), int'($urandom_range(255)),
             int'($urandom_range(255)), -1);
    endtask

    initial begin
        logic [7:0] gaps;
        bus.data_in      = '0;
        bus.data_in_done = 1'b0;

        // reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, -1);
        idle(6);

        // single white pixel
        step(1'b0, 1'b1, 255, 255, 255, 255);
        idle(5);

        // pure channels back-to-back, hand-computed values
        step(1'b0, 1'b1, 255, 0, 0, 77);
        step(1'b0, 1'b1, 0, 255, 0, 149);
        step(1'b0, 1'b1, 0, 0, 255, 29);
        step(1'b0, 1'b1, 100, 150, 200, 141);
        idle(5);

        // gapped strobes at relative cycles 0, 2, 3, 7
        gaps = 8'b1000_1101;
        for (int i = 0; i < 8; i++) rand_pix(gaps[i]);
        idle(5);

        // full frame plus one: frame_done on the 30th, wrap on the 31st
        step(1'b1, 1'b0, 0, 0, 0, -1);
        for (int i = 0; i < ROWS * COLS + 1; i++) rand_pix(1'b1);
        idle(5);

        // reset with two pixels in flight; strobe during reset must be ignored
        step(1'b1, 1'b0, 0, 0, 0, -1);
        for (int i = 0; i < 14; i++) rand_pix(1'b1);
        step(1'b1, 1'b1, 200, 10, 90, -1);
        idle(5);
        rand_pix(1'b1);
        idle(4);

        // black pixel still produces a valid strobe
        step(1'b0, 1'b1, 0, 0, 0, 0);
        idle(4);

        // random gapped stream across several frames
        for (int i = 0; i < 200; i++) rand_pix(1'($urandom_range(1)));
        idle(5);

        // every queued expectation must have been consumed
        chk("queue_drained", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
